// File: rtl/fifo_write_arbiter.sv
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Round-robin write-side arbiter that shares one FIFO write
//               port between N_REQ producers. Grants one requester at a time
//               for a burst of up to MAX_BURST words and never writes while
//               the FIFO reports full.
//               Optional macro ARB_STATS_EN adds a saturating 16-bit stall
//               counter on stall_cycles; otherwise stall_cycles is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       fifo_we,
  output logic [WIDTH-1:0]           fifo_data,
  input  logic                       fifo_full,
  input  logic                       fifo_almost_full,
  output logic                       grant_valid,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic [15:0]                stall_cycles
);

  localparam int IDW = $clog2(N_REQ);
  // Beat counter needs at least one bit even when MAX_BURST is 1.
  localparam int BW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0]  LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(N_REQ - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] gnt_q, gnt_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]  beats_q, beats_d;

  logic           found;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] gnt_next;
  logic           gnt_valid;
  logic           write;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Write qualifier; held low while reset is asserted so an aborted burst
  // never leaks a write on the reset cycle.
  always_comb begin
    gnt_valid = req_valid[gnt_q];
    gnt_next  = (gnt_q == LAST_ID) ? '0 : gnt_q + IDW'(1);
    write     = rst && (state_q == BURST) && gnt_valid && !fifo_full;
    fifo_we   = write;
    req_ready = write ? (N_REQ'(1) << gnt_q) : '0;
    fifo_data = req_data[int'(gnt_q)*WIDTH +: WIDTH];
  end

  // Next-state logic for the grant/burst state machine.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    beats_d  = beats_q;
    case (state_q)
      IDLE: begin
        // almost_full only gates new grants, never an active burst.
        if (found && !fifo_almost_full) begin
          gnt_d   = pick;
          beats_d = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (!gnt_valid) begin
          // Requester went away: end burst without writing.
          state_d  = IDLE;
          rr_ptr_d = gnt_next;
        end else if (!fifo_full) begin
          if (beats_q == LAST_BEAT) begin
            state_d  = IDLE;
            rr_ptr_d = gnt_next;
          end else begin
            beats_d = beats_q + BW'(1);
          end
        end
        // Full with valid request: stall, everything held.
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      beats_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      beats_q  <= beats_d;
    end
  end

  assign grant_valid = (state_q == BURST);
  assign grant_id    = gnt_q;

`ifdef ARB_STATS_EN
  logic        stall_cond;
  logic [15:0] stall_q, stall_d;

  // Saturating count of cycles a valid grantee is blocked by a full FIFO.
  always_comb begin
    stall_cond = (state_q == BURST) && gnt_valid && fifo_full;
    stall_d    = stall_q;
    if (stall_cond && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Stall counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

`default_nettype wire
